// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: EX/MEM and MEM/WB bundle bit positions,
// RV32 load/store funct3 encodings and the MEM-stage FSM state type.
package pipeline_pkg;

  localparam int unsigned MEMREAD  = 35;
  localparam int unsigned MEMWRITE = 34;
  localparam int unsigned MEMTOREG = 33;
  localparam int unsigned REGWRITE = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } mem_state_e;

endpackage

// File: rtl/load_store_align.sv
// Sub-word store lane steering (byte enables, replicated write data) and
// load lane selection with sign/zero extension for the MEM stage.
module load_store_align
  import pipeline_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    be    = 4'hF;
    wdata = store_data;
    case (funct3)
      F3_SB: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      F3_SH: begin
        be    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'hF;
        wdata = store_data;
      end
    endcase
  end

  always_comb begin
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   load_data = {{24{byte_lane[7]}}, byte_lane};
      F3_LH:   load_data = {{16{half_lane[15]}}, half_lane};
      F3_LBU:  load_data = {24'h0, byte_lane};
      F3_LHU:  load_data = {16'h0, half_lane};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/instruction_memory_access.sv
// MEM stage: forwards ALU ops to MEM/WB in one cycle, runs loads/stores over a
// ready-handshaked data port. MEM_SUBWORD_EN enables byte/halfword accesses.
module instruction_memory_access
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            EXMEM_VALID,
  input  logic [35:0]     EXMEM,
  input  logic [XLEN-1:0] ALU_RESULT,
  input  logic [XLEN-1:0] STORE_DATA,
  input  logic            FLUSH,
  output logic            DMEM_REQ,
  output logic            DMEM_WE,
  output logic [XLEN-1:0] DMEM_ADDR,
  output logic [XLEN-1:0] DMEM_WDATA,
  output logic [3:0]      DMEM_BE,
  input  logic [XLEN-1:0] DMEM_RDATA,
  input  logic            DMEM_READY,
  output logic [33:0]     MEMWB,
  output logic [XLEN-1:0] MEM_DATA,
  output logic [XLEN-1:0] ALU_DATA,
  output logic            MEMWB_VALID,
  output logic            STALL
);

  mem_state_e      state, next_state;

  logic [35:0]     lat_exmem;
  logic [XLEN-1:0] lat_addr;
  logic [XLEN-1:0] lat_wdata;

  logic            live;
  logic            is_mem;
  logic            lat_we;
  logic            lat_load;

  logic [3:0]      aligned_be;
  logic [XLEN-1:0] aligned_wdata;
  logic [XLEN-1:0] load_data;

  assign live     = EXMEM_VALID && !FLUSH;
  assign is_mem   = EXMEM[MEMREAD] || EXMEM[MEMWRITE];
  // MemWrite takes priority when both memory bits are set
  assign lat_we   = lat_exmem[MEMWRITE];
  assign lat_load = lat_exmem[MEMREAD] && !lat_exmem[MEMWRITE];

`ifdef MEM_SUBWORD_EN
  logic [2:0] lat_funct3;

  load_store_align u_align (
    .funct3     (lat_funct3),
    .addr_lo    (lat_addr[1:0]),
    .store_data (lat_wdata),
    .rdata      (DMEM_RDATA),
    .be         (aligned_be),
    .wdata      (aligned_wdata),
    .load_data  (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_funct3 <= '0;
    end else if (state == S_IDLE && live && is_mem) begin
      lat_funct3 <= EXMEM[14:12];
    end
  end
`else
  assign aligned_be    = 4'hF;
  assign aligned_wdata = lat_wdata;
  assign load_data     = DMEM_RDATA;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // DMEM outputs come only from latched values so they hold across READY-low cycles
  always_comb begin
    next_state = state;
    DMEM_REQ   = 1'b0;
    DMEM_WE    = 1'b0;
    DMEM_ADDR  = '0;
    DMEM_WDATA = '0;
    DMEM_BE    = '0;
    STALL      = 1'b0;
    case (state)
      S_IDLE: begin
        if (live && is_mem) next_state = S_ACCESS;
      end
      S_ACCESS: begin
        DMEM_REQ  = 1'b1;
        STALL     = 1'b1;
        DMEM_WE   = lat_we;
        DMEM_ADDR = {lat_addr[XLEN-1:2], 2'b00};
        // byte enables and write data qualify writes only
        if (lat_we) begin
          DMEM_WDATA = aligned_wdata;
          DMEM_BE    = aligned_be;
        end
        if (DMEM_READY) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_exmem <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (state == S_IDLE && live && is_mem) begin
      lat_exmem <= EXMEM;
      lat_addr  <= ALU_RESULT;
      lat_wdata <= STORE_DATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MEMWB       <= '0;
      MEM_DATA    <= '0;
      ALU_DATA    <= '0;
      MEMWB_VALID <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (live && !is_mem) begin
            MEMWB       <= {EXMEM[MEMTOREG], EXMEM[REGWRITE], EXMEM[31:0]};
            ALU_DATA    <= ALU_RESULT;
            MEM_DATA    <= '0;
            MEMWB_VALID <= 1'b1;
          end else begin
            MEMWB       <= '0;
            ALU_DATA    <= '0;
            MEM_DATA    <= '0;
            MEMWB_VALID <= 1'b0;
          end
        end
        S_ACCESS: begin
          if (DMEM_READY) begin
            MEMWB       <= {lat_exmem[MEMTOREG], lat_exmem[REGWRITE], lat_exmem[31:0]};
            ALU_DATA    <= lat_addr;
            MEM_DATA    <= lat_load ? load_data : '0;
            MEMWB_VALID <= 1'b1;
          end
        end
        default: begin
          MEMWB       <= '0;
          ALU_DATA    <= '0;
          MEM_DATA    <= '0;
          MEMWB_VALID <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_memory_access.sv
// Directed bench for the MEM stage; expectations for sub-word ops follow
// whether MEM_SUBWORD_EN is defined.
module tb_instruction_memory_access;

`ifdef MEM_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        EXMEM_VALID;
  logic [35:0] EXMEM;
  logic [31:0] ALU_RESULT;
  logic [31:0] STORE_DATA;
  logic        FLUSH;
  logic        DMEM_REQ;
  logic        DMEM_WE;
  logic [31:0] DMEM_ADDR;
  logic [31:0] DMEM_WDATA;
  logic [3:0]  DMEM_BE;
  logic [31:0] DMEM_RDATA;
  logic        DMEM_READY;
  logic [33:0] MEMWB;
  logic [31:0] MEM_DATA;
  logic [31:0] ALU_DATA;
  logic        MEMWB_VALID;
  logic        STALL;

  int checks = 0;
  int errors = 0;

  instruction_memory_access #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .EXMEM_VALID (EXMEM_VALID),
    .EXMEM       (EXMEM),
    .ALU_RESULT  (ALU_RESULT),
    .STORE_DATA  (STORE_DATA),
    .FLUSH       (FLUSH),
    .DMEM_REQ    (DMEM_REQ),
    .DMEM_WE     (DMEM_WE),
    .DMEM_ADDR   (DMEM_ADDR),
    .DMEM_WDATA  (DMEM_WDATA),
    .DMEM_BE     (DMEM_BE),
    .DMEM_RDATA  (DMEM_RDATA),
    .DMEM_READY  (DMEM_READY),
    .MEMWB       (MEMWB),
    .MEM_DATA    (MEM_DATA),
    .ALU_DATA    (ALU_DATA),
    .MEMWB_VALID (MEMWB_VALID),
    .STALL       (STALL)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    EXMEM_VALID = 1'b0;
    EXMEM       = '0;
    ALU_RESULT  = '0;
    STORE_DATA  = '0;
    FLUSH       = 1'b0;
    DMEM_RDATA  = '0;
    DMEM_READY  = 1'b0;
    tick();
    tick();

    // reset state
    check("rst_memwb", 64'(MEMWB), 64'h0);
    check("rst_valid", 64'(MEMWB_VALID), 64'h0);
    check("rst_req", 64'(DMEM_REQ), 64'h0);
    check("rst_we", 64'(DMEM_WE), 64'h0);
    check("rst_stall", 64'(STALL), 64'h0);
    check("rst_addr", 64'(DMEM_ADDR), 64'h0);
    check("rst_wdata", 64'(DMEM_WDATA), 64'h0);
    check("rst_be", 64'(DMEM_BE), 64'h0);
    check("rst_alu", 64'(ALU_DATA), 64'h0);
    check("rst_memdata", 64'(MEM_DATA), 64'h0);
    rst_n = 1'b1;

    // ADD: RegWrite only, single-cycle pass-through
    EXMEM_VALID = 1'b1;
    EXMEM       = 36'h1_00000080;
    ALU_RESULT  = 32'h10;
    DMEM_READY  = 1'b1;
    tick();
    check("add_memwb", 64'(MEMWB), 64'h1_00000080);
    check("add_alu", 64'(ALU_DATA), 64'h10);
    check("add_valid", 64'(MEMWB_VALID), 64'h1);
    check("add_stall", 64'(STALL), 64'h0);
    check("add_req", 64'(DMEM_REQ), 64'h0);

    // LW at 0x104, READY low for two ACCESS cycles
    EXMEM       = 36'hB_00002083;
    ALU_RESULT  = 32'h104;
    DMEM_READY  = 1'b0;
    tick();
    EXMEM_VALID = 1'b0;
    ALU_RESULT  = 32'hFFFF_FFFF;
    check("lw_stall1", 64'(STALL), 64'h1);
    check("lw_req", 64'(DMEM_REQ), 64'h1);
    check("lw_we", 64'(DMEM_WE), 64'h0);
    check("lw_addr1", 64'(DMEM_ADDR), 64'h104);
    check("lw_bubble_memwb", 64'(MEMWB), 64'h0);
    check("lw_bubble_valid", 64'(MEMWB_VALID), 64'h0);
    tick();
    check("lw_stall2", 64'(STALL), 64'h1);
    check("lw_addr2", 64'(DMEM_ADDR), 64'h104);
    tick();
    check("lw_stall3", 64'(STALL), 64'h1);
    check("lw_addr3", 64'(DMEM_ADDR), 64'h104);
    DMEM_READY = 1'b1;
    DMEM_RDATA = 32'hDEADBEEF;
    tick();
    check("lw_memdata", 64'(MEM_DATA), 64'hDEADBEEF);
    check("lw_memwb", 64'(MEMWB), 64'h3_00002083);
    check("lw_alu", 64'(ALU_DATA), 64'h104);
    check("lw_valid", 64'(MEMWB_VALID), 64'h1);
    check("lw_stall_end", 64'(STALL), 64'h0);
    check("lw_be_idle", 64'(DMEM_BE), 64'h0);

    // LB at 0x103
    EXMEM_VALID = 1'b1;
    EXMEM       = 36'hB_00000083;
    ALU_RESULT  = 32'h103;
    DMEM_RDATA  = 32'h80FF0000;
    tick();
    EXMEM_VALID = 1'b0;
    check("lb_addr", 64'(DMEM_ADDR), 64'h100);
    tick();
    check("lb_memdata", 64'(MEM_DATA), SUBWORD ? 64'hFFFFFF80 : 64'h80FF0000);

    // LBU at 0x103
    EXMEM_VALID = 1'b1;
    EXMEM       = 36'hB_00004083;
    tick();
    EXMEM_VALID = 1'b0;
    tick();
    check("lbu_memdata", 64'(MEM_DATA), SUBWORD ? 64'h00000080 : 64'h80FF0000);

    // LH at 0x102 (upper half)
    EXMEM_VALID = 1'b1;
    EXMEM       = 36'hB_00001083;
    ALU_RESULT  = 32'h102;
    tick();
    EXMEM_VALID = 1'b0;
    tick();
    check("lh_memdata", 64'(MEM_DATA), SUBWORD ? 64'hFFFF80FF : 64'h80FF0000);

    // SB at 0x102
    EXMEM_VALID = 1'b1;
    EXMEM       = 36'h4_00000023;
    ALU_RESULT  = 32'h102;
    STORE_DATA  = 32'h000000A5;
    DMEM_READY  = 1'b0;
    tick();
    EXMEM_VALID = 1'b0;
    check("sb_we", 64'(DMEM_WE), 64'h1);
    check("sb_be", 64'(DMEM_BE), SUBWORD ? 64'h4 : 64'hF);
    check("sb_wdata", 64'(DMEM_WDATA), SUBWORD ? 64'hA5A5A5A5 : 64'h000000A5);
    check("sb_addr", 64'(DMEM_ADDR), 64'h100);
    DMEM_READY = 1'b1;
    tick();
    check("sb_memwb", 64'(MEMWB), 64'h0_00000023);
    check("sb_valid", 64'(MEMWB_VALID), 64'h1);
    check("sb_memdata", 64'(MEM_DATA), 64'h0);
    check("sb_alu", 64'(ALU_DATA), 64'h102);

    // SH at 0x106
    EXMEM_VALID = 1'b1;
    EXMEM       = 36'h4_00001023;
    ALU_RESULT  = 32'h106;
    STORE_DATA  = 32'h1234ABCD;
    DMEM_READY  = 1'b0;
    tick();
    EXMEM_VALID = 1'b0;
    check("sh_be", 64'(DMEM_BE), SUBWORD ? 64'hC : 64'hF);
    check("sh_wdata", 64'(DMEM_WDATA), SUBWORD ? 64'hABCDABCD : 64'h1234ABCD);
    DMEM_READY = 1'b1;
    tick();

    // MemRead and MemWrite both set: store wins
    EXMEM_VALID = 1'b1;
    EXMEM       = 36'hF_00002023;
    ALU_RESULT  = 32'h108;
    STORE_DATA  = 32'hCAFEF00D;
    DMEM_RDATA  = 32'h55555555;
    DMEM_READY  = 1'b0;
    tick();
    EXMEM_VALID = 1'b0;
    check("rw_we", 64'(DMEM_WE), 64'h1);
    check("rw_be", 64'(DMEM_BE), 64'hF);
    check("rw_wdata", 64'(DMEM_WDATA), 64'hCAFEF00D);
    DMEM_READY = 1'b1;
    tick();
    check("rw_memdata", 64'(MEM_DATA), 64'h0);
    check("rw_memwb", 64'(MEMWB), 64'h3_00002023);

    // FLUSH on a live ADD in IDLE
    EXMEM_VALID = 1'b1;
    EXMEM       = 36'h1_00000080;
    ALU_RESULT  = 32'h10;
    FLUSH       = 1'b1;
    tick();
    check("flush_memwb", 64'(MEMWB), 64'h0);
    check("flush_valid", 64'(MEMWB_VALID), 64'h0);
    check("flush_alu", 64'(ALU_DATA), 64'h0);
    check("flush_stall", 64'(STALL), 64'h0);

    // FLUSH during ACCESS is ignored
    FLUSH      = 1'b0;
    EXMEM      = 36'hB_00002083;
    ALU_RESULT = 32'h200;
    DMEM_READY = 1'b0;
    tick();
    EXMEM_VALID = 1'b0;
    FLUSH       = 1'b1;
    check("flacc_stall", 64'(STALL), 64'h1);
    tick();
    check("flacc_req", 64'(DMEM_REQ), 64'h1);
    DMEM_READY = 1'b1;
    DMEM_RDATA = 32'h12345678;
    tick();
    FLUSH = 1'b0;
    check("flacc_valid", 64'(MEMWB_VALID), 64'h1);
    check("flacc_memdata", 64'(MEM_DATA), 64'h12345678);
    check("flacc_alu", 64'(ALU_DATA), 64'h200);

    // reset pulsed mid-ACCESS
    EXMEM_VALID = 1'b1;
    EXMEM       = 36'hB_00002083;
    ALU_RESULT  = 32'h300;
    DMEM_READY  = 1'b0;
    tick();
    EXMEM_VALID = 1'b0;
    check("rstacc_stall_pre", 64'(STALL), 64'h1);
    rst_n = 1'b0;
    #1;
    check("rstacc_req", 64'(DMEM_REQ), 64'h0);
    check("rstacc_stall", 64'(STALL), 64'h0);
    check("rstacc_memwb", 64'(MEMWB), 64'h0);
    check("rstacc_valid", 64'(MEMWB_VALID), 64'h0);
    #1;
    rst_n      = 1'b1;
    DMEM_READY = 1'b1;
    tick();
    check("rstacc_idle_stall", 64'(STALL), 64'h0);
    check("rstacc_idle_req", 64'(DMEM_REQ), 64'h0);
    check("rstacc_idle_valid", 64'(MEMWB_VALID), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
